// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: shares one round-iterative AES core between an encrypt requester (port 0) and a decrypt requester (port 1).
// Latency: request handshake in cycle t -> LOAD t+1, rounds t+2..t+Nr+1, res_valid from t+Nr+2; issue interval Nr+3.
// Backpressure: res_valid/res_data/res_owner hold until res_ready; requests see ready only while idle and wait otherwise.
module aes_round_scheduler #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic [N-1:0] core_data,
  output logic         core_load,
  output logic         core_step,
  output logic         core_final,
  output logic         core_decrypt,
  output logic [3:0]   key_idx,
  input  logic [N-1:0] core_state,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  output logic         res_owner,
  input  logic         res_ready,
  output logic         busy
);

  // Round-key indices are 4 bits wide, so Nr is bounded to 1..15; Nk only
  // matters to key expansion and is checked here for a sane value.
  if (Nr < 1 || Nr > 15 || Nk < 1) begin : g_cfg_check
    $error("aes_round_scheduler: Nr must be 1..15 and Nk positive");
  end

  localparam logic [3:0] NR_IDX = 4'(Nr);
  localparam logic [3:0] NR_M1  = 4'(Nr - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] rnd_cnt;
  logic       last_grant;
  logic       grant_vld;
  logic       grant_sel;

  // Round-robin grant, offered only while idle and out of reset; a tie goes
  // to the port that did not win last time.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (reset && state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_sel = ~last_grant;
      end else if (req0_valid || req1_valid) begin
        grant_vld = 1'b1;
        grant_sel = req1_valid;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_sel;
  assign req1_ready = grant_vld &  grant_sel;

  // Block sequencer: capture on grant, one load cycle, Nr-1 plain rounds,
  // one final round, then hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      rnd_cnt      <= '0;
      core_data    <= '0;
      core_decrypt <= 1'b0;
      res_owner    <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            core_data    <= grant_sel ? req1_data : req0_data;
            core_decrypt <= grant_sel;
            res_owner    <= grant_sel;
            last_grant   <= grant_sel;
            rnd_cnt      <= '0;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          rnd_cnt <= 4'd1;
          state   <= (Nr == 1) ? S_FINAL : S_ROUND;
        end
        S_ROUND: begin
          // Counter reaches Nr exactly as we leave for FINAL, never beyond.
          rnd_cnt <= rnd_cnt + 4'd1;
          if (rnd_cnt == NR_M1) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            rnd_cnt <= '0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Core controls from state and counter; decrypt walks the key schedule
  // backwards from Nr to 0.
  always_comb begin
    core_load  = 1'b0;
    core_step  = 1'b0;
    core_final = 1'b0;
    key_idx    = 4'd0;
    case (state)
      S_LOAD: begin
        core_load = 1'b1;
        key_idx   = core_decrypt ? NR_IDX : 4'd0;
      end
      S_ROUND: begin
        core_step = 1'b1;
        key_idx   = core_decrypt ? (NR_IDX - rnd_cnt) : rnd_cnt;
      end
      S_FINAL: begin
        core_step  = 1'b1;
        core_final = 1'b1;
        key_idx    = core_decrypt ? 4'd0 : NR_IDX;
      end
      default: begin
        key_idx = 4'd0;
      end
    endcase
  end

  // Result view: the core is frozen in DONE, so its state is the result.
  assign res_valid = (state == S_DONE);
  assign res_data  = res_valid ? core_state : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: a behavioural AES-128 round core driven by the
// scheduler, table-driven block vectors with a result scoreboard, plus
// sequences for arbitration, result backpressure, mid-block reset and Nr=14.
module tb_aes_round_scheduler;

  localparam int NR = 10;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ST_B = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready, core_load, core_step, core_final, core_decrypt;
  logic         res_valid, res_owner, busy;
  logic [3:0]   key_idx;
  logic [127:0] core_data, res_data;
  logic [127:0] core_st = '0;

  logic         b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_res_ready = 1'b1;
  logic [127:0] b_req0_data = '0, b_req1_data = '0;
  logic [127:0] b_core_state = ST_B;
  logic         b_req0_ready, b_req1_ready, b_core_load, b_core_step, b_core_final, b_core_decrypt;
  logic         b_res_valid, b_res_owner, b_busy;
  logic [3:0]   b_key_idx;
  logic [127:0] b_core_data, b_res_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {logic owner; logic [127:0] data;} exp_t;
  exp_t sb[$];

  typedef struct {logic port; logic [127:0] din; logic [127:0] dout;} vec_t;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_scheduler #(.N(128), .Nr(NR), .Nk(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .core_data(core_data), .core_load(core_load), .core_step(core_step),
    .core_final(core_final), .core_decrypt(core_decrypt), .key_idx(key_idx),
    .core_state(core_st), .res_valid(res_valid), .res_data(res_data),
    .res_owner(res_owner), .res_ready(res_ready), .busy(busy)
  );

  aes_round_scheduler #(.N(128), .Nr(14), .Nk(8)) dut14 (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .core_data(b_core_data), .core_load(b_core_load), .core_step(b_core_step),
    .core_final(b_core_final), .core_decrypt(b_core_decrypt), .key_idx(b_key_idx),
    .core_state(b_core_state), .res_valid(b_res_valid), .res_data(b_res_data),
    .res_owner(b_res_owner), .res_ready(b_res_ready), .busy(b_busy)
  );

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  task automatic init_tables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= NR) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else rk[r] = '0;
    end
  endtask

  function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[r+4*((c+r)%4)] = isbox[b[r+4*c]];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    o = o ^ k;
    if (!last) begin
      for (int i = 0; i < 16; i++) t[i] = o[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        t[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        t[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        t[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= NR; r++) s = fwd_round(s, rk[r], r == NR);
    return s;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] c);
    logic [127:0] s;
    s = c ^ rk[NR];
    for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  // Shared round core driven only by the scheduler's controls.
  always @(posedge clk) begin
    if (core_load) core_st <= core_data ^ rk[key_idx];
    else if (core_step) core_st <= core_decrypt ? inv_round(core_st, rk[key_idx], core_final)
                                                : fwd_round(core_st, rk[key_idx], core_final);
  end

  // ---------------- bench helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected_result: got %0h expected none", tag, res_data);
    end else begin
      e = sb.pop_front();
      chk({tag, " res_data"}, res_data, e.data);
      chk({tag, " res_owner"}, 128'(res_owner), 128'(e.owner));
    end
  endtask

  task automatic send(input logic port, input logic [127:0] d, input logic [127:0] exp_d, output int hs);
    bit got;
    exp_t e;
    got = 0;
    hs = -1;
    if (port) begin req1_valid = 1'b1; req1_data = d; end
    else begin req0_valid = 1'b1; req0_data = d; end
    #1;
    for (int i = 0; i < 60 && !got; i++) begin
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        got = 1;
        hs = cyc;
        e.owner = port;
        e.data = exp_d;
        sb.push_back(e);
      end else step();
    end
    chk("grant_seen", 128'(got), 128'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_result(input int hs, input logic dec, input string tag);
    int ntr, at;
    bit seen;
    logic [3:0] idx_tr [NR+1];
    logic       fin_tr [NR+1];
    ntr = 0; at = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (res_valid) begin
        seen = 1;
        at = cyc;
      end else begin
        if (core_load || core_step) begin
          if (ntr <= NR) begin idx_tr[ntr] = key_idx; fin_tr[ntr] = core_final; end
          ntr++;
        end
        step();
      end
    end
    chk({tag, " res_valid_seen"}, 128'(seen), 128'd1);
    chk({tag, " latency"}, 128'(at - hs), 128'(NR + 2));
    chk({tag, " trace_len"}, 128'(ntr), 128'(NR + 1));
    if (seen && ntr == NR + 1) begin
      for (int k = 0; k <= NR; k++) begin
        chk($sformatf("%s key_idx[%0d]", tag, k), 128'(idx_tr[k]), 128'(dec ? NR - k : k));
        chk($sformatf("%s final[%0d]", tag, k), 128'(fin_tr[k]), 128'(k == NR));
      end
    end
    res_ready = 1'b1;
    #1;
    if (seen) sb_check_out(tag);
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      if (res_valid && res_ready) sb_check_out(tag);
      step();
    end
    chk({tag, " drained"}, 128'(sb.size()), 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs [4];
    int hs, last_hs, grants, ntr, at;
    logic exp_port;
    bit found, seen;
    logic [127:0] rnd_blk;
    logic [3:0] idx14 [15];
    logic fin14 [15];

    init_tables();
    expand_key(KEY);
    rnd_blk = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{1'b0, PT, CT};
    vecs[1] = '{1'b1, CT, PT};
    vecs[2] = '{1'b0, 128'h0, ref_enc(128'h0)};
    vecs[3] = '{1'b1, rnd_blk, ref_dec(rnd_blk)};

    // Reset state, with a request pending that must not see ready.
    reset = 1'b0;
    req1_valid = 1'b1;
    b_req0_valid = 1'b1;
    step();
    step();
    chk("reset ctrl", 128'({req0_ready, req1_ready, core_load, core_step, core_final, core_decrypt,
                            key_idx, res_valid, res_owner, busy}), 128'd0);
    chk("reset core_data", core_data, 128'd0);
    chk("reset res_data", res_data, 128'd0);
    chk("reset nr14 ctrl", 128'({b_req0_ready, b_req1_ready, b_core_load, b_core_step, b_core_final,
                                 b_core_decrypt, b_key_idx, b_res_valid, b_res_owner, b_busy}), 128'd0);
    req1_valid = 1'b0;
    b_req0_valid = 1'b0;
    reset = 1'b1;
    step();

    // Table-driven single-block vectors.
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].port, vecs[v].din, vecs[v].dout, hs);
      wait_result(hs, vecs[v].port, $sformatf("vec%0d", v));
    end

    // Both requesters valid from reset: alternating grants, fixed issue interval.
    reset = 1'b0;
    req0_valid = 1'b1; req0_data = PT;
    req1_valid = 1'b1; req1_data = CT;
    res_ready = 1'b1;
    step();
    reset = 1'b1;
    #1;
    grants = 0; last_hs = -1; exp_port = 1'b0;
    for (int i = 0; i < 80 && grants < 4; i++) begin
      chk("one_ready", 128'(req0_ready & req1_ready), 128'd0);
      if (res_valid) sb_check_out("arb");
      if (req0_ready || req1_ready) begin
        exp_t e;
        chk("arb grant_port", 128'(req1_ready), 128'(exp_port));
        if (last_hs >= 0) chk("arb issue_interval", 128'(cyc - last_hs), 128'(NR + 3));
        last_hs = cyc;
        e.owner = req1_ready;
        e.data = req1_ready ? PT : CT;
        sb.push_back(e);
        exp_port = ~exp_port;
        grants++;
      end
      step();
    end
    chk("arb grants", 128'(grants), 128'd4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("arb");

    // Result backpressure: DONE holds for 20 cycles while a request waits.
    res_ready = 1'b0;
    send(1'b0, PT, CT, hs);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (res_valid) seen = 1;
      else step();
    end
    chk("bp res_valid_seen", 128'(seen), 128'd1);
    req1_valid = 1'b1;
    req1_data = CT;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp hold ctrl", 128'({res_valid, res_owner, req0_ready, req1_ready, core_load, core_step, busy}),
          128'(7'b1000001));
      chk("bp hold data", res_data, CT);
    end
    req1_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    sb_check_out("bp");
    step();
    chk("bp release", 128'({busy, res_valid}), 128'd0);

    // Asynchronous reset in the middle of the rounds.
    send(1'b0, PT, CT, hs);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (core_step && key_idx == 4'd5) found = 1;
      else step();
    end
    chk("rst found_idx5", 128'(found), 128'd1);
    reset = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("rst ctrl", 128'({req0_ready, req1_ready, core_load, core_step, core_final, core_decrypt,
                          key_idx, res_valid, res_owner, busy}), 128'd0);
    chk("rst core_data", core_data, 128'd0);
    chk("rst res_data", res_data, 128'd0);
    sb.delete();
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    step();
    send(1'b0, PT, CT, hs);
    wait_result(hs, 1'b0, "post_rst");

    // Nr=14 build: key index walk and latency.
    b_res_ready = 1'b1;
    b_req0_data = PT;
    b_req0_valid = 1'b1;
    #1;
    chk("nr14 ready", 128'(b_req0_ready), 128'd1);
    chk("nr14 idle res_data", b_res_data, 128'd0);
    hs = cyc;
    step();
    b_req0_valid = 1'b0;
    chk("nr14 core_data", b_core_data, PT);
    ntr = 0; at = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (b_res_valid) begin
        seen = 1;
        at = cyc;
      end else begin
        if (b_core_load || b_core_step) begin
          if (ntr < 15) begin idx14[ntr] = b_key_idx; fin14[ntr] = b_core_final; end
          ntr++;
        end
        step();
      end
    end
    chk("nr14 latency", 128'(at - hs), 128'd16);
    chk("nr14 trace_len", 128'(ntr), 128'd15);
    if (ntr == 15) begin
      for (int k = 0; k < 15; k++) begin
        chk($sformatf("nr14 key_idx[%0d]", k), 128'(idx14[k]), 128'(k));
        chk($sformatf("nr14 final[%0d]", k), 128'(fin14[k]), 128'(k == 14));
      end
    end
    chk("nr14 res_data", b_res_data, ST_B);
    chk("nr14 owner_dec", 128'({b_res_owner, b_core_decrypt}), 128'd0);
    step();
    chk("nr14 idle", 128'({b_busy, b_res_valid}), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
